// File: rtl/fb_arb_pkg.sv
// Shared types for the frame-buffer port arbiter: grant encoding, queued write
// entry and the pixel-to-address helper.
package fb_arb_pkg;

    localparam int FB_COORD_W = 10;
    localparam int FB_DATA_W  = 8;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_DISP,
        GNT_WRITE,
        GNT_DROP
    } grant_e;

    typedef struct packed {
        logic [FB_COORD_W-1:0] x;
        logic [FB_COORD_W-1:0] y;
        logic [FB_DATA_W-1:0]  data;
    } wr_entry_t;

    // y*640 + x built from shifts so no multiplier is inferred.
    function automatic logic [31:0] fb_addr(input logic [FB_COORD_W-1:0] x,
                                            input logic [FB_COORD_W-1:0] y);
        logic [31:0] yw;
        logic [31:0] xw;
        yw = {22'd0, y};
        xw = {22'd0, x};
        return (yw << 9) + (yw << 7) + xw;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO of pending writer requests; no bypass, so a pushed
// entry becomes visible at the head one cycle after the push.
module fb_wr_fifo
    import fb_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW  = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wr_entry_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output logic [AW:0] count,
    output wr_entry_t head
);

    wr_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares one single-port frame-buffer RAM between the hard real-time display
// fetch (always wins) and a FIFO-buffered drawing writer.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int H_ADDR       = 640,
    parameter int V_ADDR       = 480,
    parameter int ADDR_WIDTH   = 19,
    parameter int DATA_WIDTH   = FB_DATA_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  disp_act,
    input  logic [9:0]            disp_x,
    input  logic [9:0]            disp_y,
    output logic [DATA_WIDTH-1:0] pixel_out,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [9:0]            wr_x,
    input  logic [9:0]            wr_y,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_drop,
    output logic                  wr_starve,
    input  logic                  starve_clr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wr_entry_t             push_entry, head;
    logic                  full, empty, push, pop;
    logic [CW:0]           count;
    grant_e                grant;
    logic [31:0]           disp_addr, head_addr;
    logic                  head_in_range;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rd_pend_q;
    logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
    logic                  starve_q, starve_d;

    assign wr_ready   = !rst && !full;
    assign push       = wr_valid && wr_ready;
    assign push_entry = '{x: wr_x, y: wr_y, data: FB_DATA_W'(wr_data)};

    fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );

    if (H_ADDR == 640) begin : g_shift_addr
        assign disp_addr = fb_addr(disp_x, disp_y);
        assign head_addr = fb_addr(head.x, head.y);
    end else begin : g_mul_addr
        assign disp_addr = {22'd0, disp_y} * 32'(H_ADDR) + {22'd0, disp_x};
        assign head_addr = {22'd0, head.y} * 32'(H_ADDR) + {22'd0, head.x};
    end

    assign head_in_range = ({22'd0, head.x} < 32'(H_ADDR)) && ({22'd0, head.y} < 32'(V_ADDR));

    // Grant is forced idle during reset so queued entries never reach the RAM.
    always_comb begin
        grant = GNT_IDLE;
        if (!rst) begin
            if (disp_act)    grant = GNT_DISP;
            else if (!empty) grant = head_in_range ? GNT_WRITE : GNT_DROP;
        end
    end

    assign pop     = (grant == GNT_WRITE) || (grant == GNT_DROP);
    assign wr_drop = (grant == GNT_DROP);

    always_comb begin
        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (grant)
            GNT_DISP:  mem_addr = disp_addr[ADDR_WIDTH-1:0];
            GNT_WRITE: begin
                mem_addr  = head_addr[ADDR_WIDTH-1:0];
                mem_we    = 1'b1;
                mem_wdata = DATA_WIDTH'(head.data);
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (pop || count == '0)
            starve_cnt_d = '0;
        else if (starve_cnt_q != SW'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt_q + SW'(1);
        // A fresh trigger overrides a simultaneous clear.
        starve_d = (starve_cnt_d == SW'(STARVE_LIMIT)) || (starve_q && !starve_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            rd_pend_q    <= 1'b0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            addr_q       <= mem_addr;
            rd_pend_q    <= (grant == GNT_DISP);
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

    assign pixel_out = rd_pend_q ? mem_rdata : '0;
    assign wr_starve = starve_q;

endmodule
